// File: rtl/arb_pkg.sv
// Shared encodings for the single-port memory arbiter: response owner and access size.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } owner_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Size code 3 has no meaning on the memory side; treat it as a word.
    function automatic logic [1:0] norm_size(input logic [1:0] sz);
        return (sz == 2'd3) ? SZ_W : sz;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-port signals of the arbiter; slave = arbiter view, master = surroundings.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_we;
    logic [1:0]        m_size;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, m_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               m_addr, m_wdata, m_we, m_size
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               m_addr, m_wdata, m_we, m_size
    );
endinterface

// File: rtl/arb_starve_ctr.sv
// Counts data grants issued while fetch waits; flags when fetch must be let through.
module arb_starve_ctr #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_req_i,
    input  logic i_gnt_i,
    input  logic d_gnt_i,
    output logic at_max_o
);
    localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_max_q;

    // Fetch served or gone resets the streak; otherwise each data grant extends it.
    always_comb begin
        cnt_d = cnt_q;
        if (i_gnt_i || !i_req_i) begin
            cnt_d = '0;
        end else if (d_gnt_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            at_max_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            at_max_q <= (cnt_d == CNT_W'(STARVE_MAX));
        end
    end

    assign at_max_o = at_max_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between fetch and load/store; data has priority.
// Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    owner_e            state_q, state_d;
    logic              st_we_q, st_we_d;
    logic              i_gnt_c, d_gnt_c;
    logic              starve_c;
    logic [ADDR_W-1:0] m_addr_c;
    logic [DATA_W-1:0] m_wdata_c;
    logic              m_we_c;
    logic [1:0]        m_size_c;
    logic              i_rvalid_c, d_rvalid_c;

`ifdef ARB_STARVE_GUARD_EN
    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk      (clk),
        .reset    (reset),
        .i_req_i  (bus.i_req),
        .i_gnt_i  (i_gnt_c),
        .d_gnt_i  (d_gnt_c),
        .at_max_o (starve_c)
    );
`else
    logic unused_starve_cfg;
    assign unused_starve_cfg = (STARVE_MAX != 0);
    assign starve_c          = 1'b0;
`endif

    // Grant: data wins unless the guard says fetch has waited long enough.
    always_comb begin
        i_gnt_c = 1'b0;
        d_gnt_c = 1'b0;
        if (!reset) begin
            if (bus.d_req && !(bus.i_req && starve_c)) begin
                d_gnt_c = 1'b1;
            end else if (bus.i_req) begin
                i_gnt_c = 1'b1;
            end
        end
    end

    always_comb begin
        m_addr_c  = '0;
        m_wdata_c = '0;
        m_we_c    = 1'b0;
        m_size_c  = SZ_W;
        if (d_gnt_c) begin
            m_addr_c  = bus.d_addr;
            m_wdata_c = bus.d_wdata;
            m_we_c    = bus.d_we;
            m_size_c  = norm_size(bus.d_size);
        end else if (i_gnt_c) begin
            m_addr_c  = bus.i_addr;
        end
    end

    // Owner of the access in flight follows this cycle's grant, so accesses pipeline.
    always_comb begin
        state_d = IDLE;
        st_we_d = 1'b0;
        if (i_gnt_c) begin
            state_d = RESP_I;
        end else if (d_gnt_c) begin
            state_d = RESP_D;
            st_we_d = bus.d_we;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            st_we_q <= 1'b0;
        end else begin
            state_q <= state_d;
            st_we_q <= st_we_d;
        end
    end

    // Reset masks a response that was already in flight when reset arrived.
    assign i_rvalid_c = !reset && (state_q == RESP_I);
    assign d_rvalid_c = !reset && (state_q == RESP_D);

    assign bus.i_gnt    = i_gnt_c;
    assign bus.d_gnt    = d_gnt_c;
    assign bus.m_addr   = m_addr_c;
    assign bus.m_wdata  = m_wdata_c;
    assign bus.m_we     = m_we_c;
    assign bus.m_size   = m_size_c;
    assign bus.i_rvalid = i_rvalid_c;
    assign bus.i_rdata  = i_rvalid_c ? bus.m_rdata : '0;
    assign bus.d_rvalid = d_rvalid_c;
    assign bus.d_rdata  = (d_rvalid_c && !st_we_q) ? bus.m_rdata : '0;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter for the RV32 core. It shares one synchronous memory port between the instruction-fetch requester and the load/store requester. It grants at most one access per cycle and routes the one-cycle-latency read response back to the owner. It sits between fetch_decode/execute and the unified `memory` instance.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, max consecutive data grants while fetch waits (only used with the guard enabled)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- i_req  in  1  fetch request, held until granted
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  fetch granted this cycle (combinational)
- i_rvalid  out  1  fetch read data valid
- i_rdata  out  DATA_W  fetch read data
- d_req  in  1  load/store request, held until granted
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  0 byte, 1 half, 2 word; 3 is treated as word
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data granted this cycle (combinational)
- d_rvalid  out  1  load data valid / store acknowledge
- d_rdata  out  DATA_W  load data
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_we  out  1  memory write enable
- m_size  out  2  memory access size
- m_rdata  in  DATA_W  memory read data, valid one cycle after address

## Operation
- Grant rule: at most one of i_gnt/d_gnt per cycle.
  - Data wins on contention.
  - A lone request is always granted.
- Memory drive:
  - On a grant, m_addr, m_size, m_wdata and m_we are driven from the granted requester.
  - Fetch always drives m_we=0 and m_size=2.
  - With no grant, m_we=0, m_addr=0, m_wdata=0 and m_size=2.
- Response FSM (state = owner of the in-flight access, registered at posedge):
  - IDLE: no access in flight.
  - RESP_I: entered after a fetch grant.
  - RESP_D: entered after a data grant.
  - The next state is set by the current cycle's grant, so back-to-back accesses are pipelined.
- Responses:
  - In RESP_I: i_rvalid=1 and i_rdata=m_rdata.
  - In RESP_D: d_rvalid=1 and d_rdata=m_rdata; a store acknowledge has d_rdata=0.
  - Non-owner rvalid is 0 and its rdata is 0.
- Simultaneous response and new grant in the same cycle is legal: the response completes and the new owner is recorded.

## Timing
- Grant is combinational from req in the same cycle.
- Response appears exactly 1 cycle after grant.
- Throughput is 1 access/cycle.
- Reset (synchronous):
  - While reset is high: all gnt=0, all rvalid=0, all rdata=0, m_we=0.
  - Next state is IDLE and the starvation counter is 0.
- Reset mid-operation: an access granted in the cycle before reset has its response dropped. No rvalid follows reset deassertion.
- Requesters must hold req and payload stable until gnt is seen. Deasserting req before gnt is allowed and withdraws the request.

## Configuration
- `ARB_STARVE_GUARD_EN` defined:
  - A counter increments on each d_gnt issued while i_req=1.
  - When the counter equals STARVE_MAX and both requests are present, fetch is granted instead and the counter clears.
  - The counter also clears on any i_gnt or when i_req=0.
- Not defined: strict data priority; counter logic is absent.

## Structure
- Shared constants package `arb_pkg`:
  - owner encoding IDLE=2'd0, RESP_I=2'd1, RESP_D=2'd2
  - size encoding SZ_B=2'd0, SZ_H=2'd1, SZ_W=2'd2
- One natural sub-module, `arb_starve_ctr` (counter plus compare), instantiated only under `ARB_STARVE_GUARD_EN`.

## Test plan
- Reset: reset=1 for 2 cycles with i_req=1 and d_req=1 -> i_gnt=d_gnt=0 and all rvalid=0; the first cycle after release grants data.
- Lone fetch: i_req=1, i_addr=0x10, memory word 0x00500093 -> i_gnt=1 in the same cycle; next cycle i_rvalid=1 and i_rdata=0x00500093.
- Contention: i_req=d_req=1 with d_we=0, d_addr=0x100 -> d_gnt=1, i_gnt=0, m_addr=0x100; next cycle d_rvalid=1 and the fetch is granted.
- Store: d_we=1, d_size=2, d_addr=0x200, d_wdata=0xDEADBEEF -> m_we=1 for one cycle; next cycle d_rvalid=1 and d_rdata=0; a subsequent load from 0x200 returns 0xDEADBEEF.
- Starvation (`ARB_STARVE_GUARD_EN`, STARVE_MAX=4): d_req and i_req held high -> 4 data grants, then 1 fetch grant, repeating. Without the macro, i_gnt stays 0.
- Reset mid-access: grant a fetch, assert reset on the next edge -> i_rvalid stays 0 and the FSM is IDLE afterwards.
